// File: rtl/minute_timer.sv
// Programmable tick generator: STOPPED/RUNNING/PAUSED FSM that pulses TimerFlag every TimerStartPoint cycles.
// Optional status ports (TimerCount, TimerActive) are built only when TIMER_STATUS_EN is defined.
module minute_timer #(
  parameter int CNT_WIDTH = 5
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [1:0]           TimerMode,
  input  logic [CNT_WIDTH-1:0] TimerStartPoint,
  output logic                 TimerFlag
`ifdef TIMER_STATUS_EN
  ,
  output logic [CNT_WIDTH-1:0] TimerCount,
  output logic                 TimerActive
`endif
);

  typedef enum logic [1:0] {
    ST_STOPPED = 2'd0,
    ST_RUNNING = 2'd1,
    ST_PAUSED  = 2'd2
  } state_t;

  localparam logic [1:0] MODE_RUN   = 2'b00;
  localparam logic [1:0] MODE_PAUSE = 2'b01;

  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   count_q, count_d;
  logic                   flag_q, flag_d;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_STOPPED;
      count_q <= '0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      flag_q  <= flag_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    flag_d  = 1'b0;
    case (state_q)
      ST_STOPPED: begin
        count_d = CNT_ZERO;
        if (TimerMode == MODE_RUN) begin
          state_d = ST_RUNNING;
          count_d = TimerStartPoint;
        end
      end
      ST_RUNNING, ST_PAUSED: begin
        case (TimerMode)
          MODE_RUN: begin
            // Resuming from PAUSED counts this edge, so total RUN edges per period stay equal to the start point.
            state_d = ST_RUNNING;
            if (count_q == CNT_ZERO) begin
              count_d = TimerStartPoint;
            end else if (count_q == CNT_ONE) begin
              flag_d  = 1'b1;
              count_d = TimerStartPoint;
            end else begin
              count_d = count_q - CNT_ONE;
            end
          end
          MODE_PAUSE: begin
            state_d = ST_PAUSED;
          end
          default: begin
            state_d = ST_STOPPED;
            count_d = CNT_ZERO;
          end
        endcase
      end
      default: begin
        state_d = ST_STOPPED;
        count_d = CNT_ZERO;
      end
    endcase
  end

  assign TimerFlag = flag_q;

`ifdef TIMER_STATUS_EN
  logic active_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      active_q <= 1'b0;
    end else begin
      active_q <= (state_d != ST_STOPPED);
    end
  end

  assign TimerCount  = count_q;
  assign TimerActive = active_q;
`endif

endmodule

// File: tb/tb_minute_timer.sv
// Directed bench for minute_timer: a period/elapsed reference model checked every cycle plus literal flag patterns.
module tb_minute_timer;
  localparam int W = 5;
  localparam logic [1:0] RUN   = 2'b00;
  localparam logic [1:0] PAUSE = 2'b01;
  localparam logic [1:0] STOP  = 2'b10;
  localparam logic [1:0] RSV   = 2'b11;

  logic         CLK = 1'b0;
  logic         RST;
  logic [1:0]   TimerMode;
  logic [W-1:0] TimerStartPoint;
  logic         TimerFlag;
`ifdef TIMER_STATUS_EN
  logic [W-1:0] TimerCount;
  logic         TimerActive;
`endif

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  always #5 CLK = ~CLK;

  minute_timer #(.CNT_WIDTH(W)) dut (
    .CLK             (CLK),
    .RST             (RST),
    .TimerMode       (TimerMode),
    .TimerStartPoint (TimerStartPoint),
    .TimerFlag       (TimerFlag)
`ifdef TIMER_STATUS_EN
    ,
    .TimerCount      (TimerCount),
    .TimerActive     (TimerActive)
`endif
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a period latched at load/reload and the number of RUN edges elapsed within it.
  bit m_active, m_flag;
  int m_period, m_elapsed;

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      m_active = 0; m_flag = 0; m_period = 0; m_elapsed = 0;
    end else begin
      m_flag = 0;
      if (TimerMode == RUN) begin
        if (!m_active) begin
          m_active = 1; m_period = int'(TimerStartPoint); m_elapsed = 0;
        end else if (m_period == 0) begin
          m_period = int'(TimerStartPoint); m_elapsed = 0;
        end else begin
          m_elapsed++;
          if (m_elapsed == m_period) begin
            m_flag = 1; m_period = int'(TimerStartPoint); m_elapsed = 0;
          end
        end
      end else if (TimerMode != PAUSE) begin
        m_active = 0; m_period = 0; m_elapsed = 0;
      end
    end
  end

  always @(negedge CLK) begin
    if (started) begin
      chk("model_flag", int'(TimerFlag), int'(m_flag));
`ifdef TIMER_STATUS_EN
      chk("model_count", int'(TimerCount), m_period - m_elapsed);
      chk("model_active", int'(TimerActive), int'(m_active));
`endif
    end
  end

  task automatic step(input logic [1:0] m);
    TimerMode = m;
    @(posedge CLK);
    #1;
  endtask

  logic [10:1] e27;
  logic [6:1]  e28;

  initial begin
    e27 = 10'b1010101010;
    e28 = 6'b100010;
    RST = 1'b0;
    TimerMode = STOP;
    TimerStartPoint = '0;
    #12;
    chk("reset_flag", int'(TimerFlag), 0);
`ifdef TIMER_STATUS_EN
    chk("reset_count", int'(TimerCount), 0);
    chk("reset_active", int'(TimerActive), 0);
`endif
    started = 1'b1;
    @(negedge CLK);
    RST = 1'b1;

    step(PAUSE); chk("stopped_pause_flag", int'(TimerFlag), 0);

    TimerStartPoint = 5'd2;
    step(RUN); chk("sp2_load_flag", int'(TimerFlag), 0);
    for (int e = 1; e <= 10; e++) begin
      step(RUN); chk("sp2_flag", int'(TimerFlag), int'(e27[e]));
    end
    step(STOP); chk("sp2_stop_flag", int'(TimerFlag), 0);

    TimerStartPoint = 5'd4;
    step(RUN); step(RUN); step(RUN);
    for (int e = 0; e < 5; e++) begin
      step(PAUSE); chk("sp4_pause_flag", int'(TimerFlag), 0);
    end
    for (int e = 1; e <= 6; e++) begin
      step(RUN); chk("sp4_resume_flag", int'(TimerFlag), int'(e28[e]));
    end
    step(STOP);

    TimerStartPoint = 5'd3;
    step(RUN); step(RUN); step(RUN);
    step(STOP); chk("sp3_stop_wins_flag", int'(TimerFlag), 0);
`ifdef TIMER_STATUS_EN
    chk("sp3_stop_count", int'(TimerCount), 0);
    chk("sp3_stop_active", int'(TimerActive), 0);
`endif
    step(RUN); step(RUN); step(RUN);
    step(RSV); chk("sp3_rsv_flag", int'(TimerFlag), 0);
    step(PAUSE); chk("sp3_rsv_stays_flag", int'(TimerFlag), 0);
    step(RUN); step(RUN); step(RUN);
    step(PAUSE); chk("sp3_pause_at_one_flag", int'(TimerFlag), 0);
    step(PAUSE); chk("sp3_pause_hold_flag", int'(TimerFlag), 0);
    step(RUN); chk("sp3_resume_tick_flag", int'(TimerFlag), 1);
    step(STOP);

    TimerStartPoint = 5'd1;
    step(RUN); chk("sp1_load_flag", int'(TimerFlag), 0);
    for (int e = 0; e < 4; e++) begin
      step(RUN); chk("sp1_flag", int'(TimerFlag), 1);
    end
    #3 RST = 1'b0;
    #1 chk("sp1_async_rst_flag", int'(TimerFlag), 0);
    #2 RST = 1'b1;

    TimerStartPoint = 5'd8;
    step(RUN);
    for (int e = 0; e < 5; e++) step(RUN);
    #3 RST = 1'b0;
    #1 chk("sp8_async_rst_flag", int'(TimerFlag), 0);
`ifdef TIMER_STATUS_EN
    chk("sp8_async_rst_count", int'(TimerCount), 0);
    chk("sp8_async_rst_active", int'(TimerActive), 0);
`endif
    #2 RST = 1'b1;
    step(RUN); chk("sp8_reload_flag", int'(TimerFlag), 0);
    for (int e = 1; e <= 8; e++) begin
      step(RUN); chk("sp8_flag", int'(TimerFlag), int'(e == 8));
    end
    step(STOP);

    TimerStartPoint = 5'd6;
    step(RUN); step(RUN);
    TimerStartPoint = 5'd2;
    for (int e = 2; e <= 10; e++) begin
      step(RUN); chk("sp6to2_flag", int'(TimerFlag), int'(e == 6 || e == 8 || e == 10));
    end
    step(STOP);

    TimerStartPoint = 5'd0;
    step(RUN);
    for (int e = 0; e < 20; e++) begin
      step(RUN); chk("sp0_flag", int'(TimerFlag), 0);
`ifdef TIMER_STATUS_EN
      chk("sp0_active", int'(TimerActive), 1);
      chk("sp0_count", int'(TimerCount), 0);
`endif
    end
    TimerStartPoint = 5'd3;
    step(RUN); chk("sp0_reload_flag", int'(TimerFlag), 0);
    for (int e = 1; e <= 3; e++) begin
      step(RUN); chk("sp0_reload_tick", int'(TimerFlag), int'(e == 3));
    end
    step(STOP);

    TimerStartPoint = 5'd31;
    step(RUN);
    for (int e = 1; e <= 33; e++) begin
      step(RUN);
      if (e == 31) chk("sp31_tick", int'(TimerFlag), 1);
    end
    step(STOP);
    step(STOP);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
